laser_host: RTL and testbench
=============================

# laser_host

Host-side driver and scorer for the LASER two-circle coverage engine. It buffers 40 target points from an upstream load port and restarts the engine with a one-cycle reset pulse. It then streams the points onto the engine's X/Y inputs at exactly the engine's RECEIVE timing and waits for the engine's DONE pulse. Finally it captures the two centres, independently recounts how many targets fall within radius 4 of either centre, and reports the result upstream.

## Interface
- N_PTS, 40: targets per pattern (index width 6).
- R2, 16: squared radius; a target is covered when dx²+dy² ≤ R2.
- TIMEOUT, 4095: max WAIT cycles before an error report (12-bit counter).
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low; all state and outputs to reset values while low.
- LD_VALID  in  1  upstream point valid.
- LD_X, LD_Y  in  4 each  upstream point coordinates.
- LD_READY  out  1  host accepts a point this cycle (LOAD state only).
- L_RST  out  1  active-high reset to engine.
- X, Y  out  4 each  point stream to engine.
- C1X, C1Y, C2X, C2Y  in  4 each  engine result centres.
- DONE  in  1  engine completion pulse.
- RES_VALID  out  1  one-cycle result strobe.
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres.
- RES_SCORE  out  6  covered-target count, 0..40.
- RES_ERR  out  1  set with RES_VALID when WAIT timed out.

## Operation
- States: LOAD, KICK, GAP, SEND, WAIT, SCORE, REPORT.
- LOAD: LD_READY=1. Each LD_VALID&LD_READY writes {LD_X,LD_Y} to buf[wr_idx], wr_idx++. On the 40th accept (wr_idx==39) → KICK, wr_idx←0.
- KICK: L_RST=1 for exactly one cycle → GAP.
- GAP: one idle cycle covering the engine's IDLE state, X=Y=0 → SEND, rd_idx←0.
- SEND: 41 cycles. Cycles 0..39 drive X/Y=buf[rd_idx]. Cycle 40 drives 0 (the engine's 41st RECEIVE cycle is discarded). → WAIT.
- WAIT: wait_cnt increments each cycle.
  - DONE=1: capture C1X..C2Y into RES_C*, clear RES_ERR → SCORE.
  - wait_cnt==TIMEOUT with DONE low: RES_C* ← 0, RES_ERR←1, RES_SCORE←0 → REPORT (SCORE skipped).
  - If DONE and timeout coincide, DONE wins.
- SCORE: 40 cycles, one point per cycle, idx 0..39.
  - dx=|px−cx| as a 4-bit unsigned compare-then-subtract, squared to 8 bits. dist = dx²+dy², 9 bits, no overflow (max 450).
  - Point hit if dist to C1 ≤ R2 or dist to C2 ≤ R2. A point inside both circles counts once.
  - Accumulator is 6-bit, cleared on SCORE entry. → REPORT after idx 39.
- REPORT: RES_VALID=1 for one cycle → LOAD. The buffer is overwritten only by new loads.
- DONE outside WAIT is ignored. LD_VALID outside LOAD is ignored, and no point is consumed.

## Timing
- Reset values: LD_READY=0, L_RST=0, X=Y=0, RES_VALID=0, RES_C*=0, RES_SCORE=0, RES_ERR=0. State LOAD is entered on the first edge after RST deasserts, so LD_READY=1 from that cycle.
- All outputs are registered or decoded from the state register only, with no combinational path from inputs.
- Engine alignment: with L_RST high in cycle t, point 0 is on X/Y in cycle t+2 and point k in cycle t+2+k. Point 39 is in cycle t+41, and zeros are in cycle t+42.
- Fixed latency from 40th accept to WAIT entry: 1 (KICK) + 1 (GAP) + 41 (SEND) = 43 cycles.
- Latency from DONE-high cycle to RES_VALID: 41 cycles (40 SCORE + 1 REPORT).
- RES_C*, RES_SCORE and RES_ERR hold their values until the next REPORT.
- RST low mid-operation aborts immediately. The partial buffer is discarded (wr_idx=0) and L_RST is deasserted.

## Test plan
- Reset: hold RST low with random inputs → all outputs 0. Release → LD_READY=1 next cycle, L_RST pulse absent.
- Load/stream alignment: load points (k mod 16, k/3) for k=0..39 with LD_VALID gaps, using a behavioral engine model → L_RST single-cycle pulse 1 cycle after the 40th accept. X/Y equal point k exactly 2+k cycles after the pulse, zero on cycle 42.
- Scoring with a fixed response: engine model returns DONE with C1=(3,3), C2=(12,12); 20 points at (3,3)±(0..2), 10 at (12,12) offset (4,0), 10 at (0,15) → RES_SCORE=30, RES_ERR=0, RES_VALID 41 cycles after DONE.
- Boundary distance: C1=C2=(0,0). Points (4,0), (0,4) and (2,3) dist 13 are hit; (3,3) dist 18 and (4,1) dist 17 are miss; (15,15) is miss → score counts only the hits. Points in both circles count once.
- Timeout: engine never raises DONE → RES_VALID after TIMEOUT+1 WAIT cycles, with RES_ERR=1, RES_SCORE=0 and RES_C*=0. A DONE arriving later is ignored.
- Mid-run reset: drop RST during SEND at point 20 → outputs return to reset values. A full reload of 40 new points then streams the new data, with no stale points.

Source files
------------

// File: rtl/laser_host.sv
// Host-side driver and scorer for the LASER two-circle coverage engine.
// Buffers 40 targets, restarts and feeds the engine, then rescores its two centres.
module laser_host #(
  parameter int N_PTS   = 40,
  parameter int R2      = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_VALID,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  output logic       LD_READY,
  output logic       L_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic       RES_VALID,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] RES_SCORE,
  output logic       RES_ERR,
  output logic [2:0] DBG_STATE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_KICK   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_SCORE  = 3'd6;
  localparam logic [2:0] S_REPORT = 3'd7;

  localparam logic [5:0]  LAST_IDX  = 6'(N_PTS - 1);
  localparam logic [5:0]  SEND_END  = 6'(N_PTS);
  localparam logic [8:0]  R2_L      = 9'(R2);
  localparam logic [11:0] TIMEOUT_L = 12'(TIMEOUT);

  // Handshake: a point is consumed on any rising edge where LD_VALID and
  // LD_READY are both high; LD_READY depends only on the state register.

  logic [2:0]  state;
  logic [7:0]  pbuf [N_PTS];
  logic [5:0]  wr_idx;
  logic [5:0]  idx;
  logic [11:0] wait_cnt;
  logic [3:0]  cap_c1x, cap_c1y, cap_c2x, cap_c2y;
  logic [5:0]  acc;
  logic [7:0]  cur_pt;
  logic [8:0]  d1, d2;
  logic        hit;

  function automatic logic [8:0] dist2(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] dx2, dy2;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dx2 = {4'b0, dx} * {4'b0, dx};
    dy2 = {4'b0, dy} * {4'b0, dy};
    return {1'b0, dx2} + {1'b0, dy2};
  endfunction

  // idx runs one past the last point during SEND so the trailing cycle reads zero
  assign cur_pt = (idx <= LAST_IDX) ? pbuf[idx] : 8'h00;
  assign d1     = dist2(cur_pt[7:4], cur_pt[3:0], cap_c1x, cap_c1y);
  assign d2     = dist2(cur_pt[7:4], cur_pt[3:0], cap_c2x, cap_c2y);
  assign hit    = (d1 <= R2_L) || (d2 <= R2_L);

  assign LD_READY  = (state == S_LOAD);
  assign L_RST     = (state == S_KICK);
  assign RES_VALID = (state == S_REPORT);
  assign X         = (state == S_SEND) ? cur_pt[7:4] : 4'h0;
  assign Y         = (state == S_SEND) ? cur_pt[3:0] : 4'h0;
  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      wr_idx    <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      acc       <= '0;
      cap_c1x   <= '0;
      cap_c1y   <= '0;
      cap_c2x   <= '0;
      cap_c2y   <= '0;
      RES_C1X   <= '0;
      RES_C1Y   <= '0;
      RES_C2X   <= '0;
      RES_C2Y   <= '0;
      RES_SCORE <= '0;
      RES_ERR   <= 1'b0;
      for (int i = 0; i < N_PTS; i++) pbuf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_LOAD;
        S_LOAD: begin
          if (LD_VALID) begin
            pbuf[wr_idx] <= {LD_X, LD_Y};
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              state  <= S_KICK;
            end else begin
              wr_idx <= wr_idx + 6'd1;
            end
          end
        end
        S_KICK: state <= S_GAP;
        S_GAP: begin
          idx   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (idx == SEND_END) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_WAIT: begin
          // DONE takes priority over a coincident timeout
          if (DONE) begin
            cap_c1x <= C1X;
            cap_c1y <= C1Y;
            cap_c2x <= C2X;
            cap_c2y <= C2Y;
            acc     <= '0;
            idx     <= '0;
            state   <= S_SCORE;
          end else if (wait_cnt == TIMEOUT_L) begin
            RES_C1X   <= '0;
            RES_C1Y   <= '0;
            RES_C2X   <= '0;
            RES_C2Y   <= '0;
            RES_SCORE <= '0;
            RES_ERR   <= 1'b1;
            state     <= S_REPORT;
          end else begin
            wait_cnt <= wait_cnt + 12'd1;
          end
        end
        S_SCORE: begin
          // Result registers change only as REPORT is entered, so they stay stable between reports
          if (idx == LAST_IDX) begin
            RES_SCORE <= acc + {5'b0, hit};
            RES_C1X   <= cap_c1x;
            RES_C1Y   <= cap_c1y;
            RES_C2X   <= cap_c2x;
            RES_C2Y   <= cap_c2y;
            RES_ERR   <= 1'b0;
            state     <= S_REPORT;
          end else begin
            acc <= acc + {5'b0, hit};
            idx <= idx + 6'd1;
          end
        end
        S_REPORT: state <= S_LOAD;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: reset, stream alignment, scoring vectors,
// timeout and mid-run reset, with a stand-in engine driving DONE and centres.
module tb_laser_host;

  logic       clk, rst;
  logic       ld_valid;
  logic [3:0] ld_x, ld_y;
  logic       ld_ready, l_rst;
  logic [3:0] x, y;
  logic [3:0] c1x, c1y, c2x, c2y;
  logic       done;
  logic       res_valid;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic [5:0] res_score;
  logic       res_err;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [3:0] pt_x [40];
  logic [3:0] pt_y [40];
  logic [7:0] exp_q [$];

  typedef struct {
    int px, py, c1x, c1y, c2x, c2y, exp_score;
  } vec_t;
  vec_t vecs [12];

  laser_host dut (
    .CLK(clk), .RST(rst), .LD_VALID(ld_valid), .LD_X(ld_x), .LD_Y(ld_y),
    .LD_READY(ld_ready), .L_RST(l_rst), .X(x), .Y(y),
    .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .DONE(done),
    .RES_VALID(res_valid), .RES_C1X(res_c1x), .RES_C1Y(res_c1y),
    .RES_C2X(res_c2x), .RES_C2Y(res_c2y), .RES_SCORE(res_score),
    .RES_ERR(res_err), .DBG_STATE(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_l_rst"}, l_rst, 0);
    chk({tag, "_xy"}, {x, y}, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_c"}, {res_c1x, res_c1y, res_c2x, res_c2y}, 0);
    chk({tag, "_res_score"}, res_score, 0);
    chk({tag, "_res_err"}, res_err, 0);
  endtask

  function automatic int model_score(input int ax, input int ay, input int bx, input int by);
    int s, px, py, da, db;
    s = 0;
    for (int k = 0; k < 40; k++) begin
      px = int'(pt_x[k]);
      py = int'(pt_y[k]);
      da = (px - ax) * (px - ax) + (py - ay) * (py - ay);
      db = (px - bx) * (px - bx) + (py - by) * (py - by);
      if (da <= 16 || db <= 16) s++;
    end
    return s;
  endfunction

  // driver: loads pt_x/pt_y; with gaps, idle cycles carry stray DONE pulses
  task automatic load_pattern(input bit gaps);
    for (int k = 0; k < 40; k++) begin
      if (gaps && (k % 3 == 1)) begin
        ld_valid = 1'b0;
        done     = 1'b1;
        tick();
        done     = 1'b0;
      end
      ld_valid = 1'b1;
      ld_x     = pt_x[k];
      ld_y     = pt_y[k];
      if (k == 0 || k == 39) chk("ld_ready_load", ld_ready, 1);
      chk("l_rst_during_load", l_rst, 0);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  // entered in the KICK cycle; leaves the bench in the first WAIT cycle
  task automatic stream_check(input bit junk_ld);
    logic [7:0] e;
    for (int k = 0; k < 40; k++) exp_q.push_back({pt_x[k], pt_y[k]});
    chk("l_rst_kick", l_rst, 1);
    chk("ld_ready_kick", ld_ready, 0);
    tick();
    chk("l_rst_single_cycle", l_rst, 0);
    chk("xy_gap_zero", {x, y}, 0);
    for (int k = 0; k < 40; k++) begin
      if (junk_ld) begin
        ld_valid = 1'b1;
        ld_x     = 4'($urandom_range(0, 15));
        ld_y     = 4'($urandom_range(0, 15));
      end
      tick();
      e = exp_q.pop_front();
      chk($sformatf("x_pt%0d", k), x, e[7:4]);
      chk($sformatf("y_pt%0d", k), y, e[3:0]);
    end
    tick();
    chk("xy_tail_zero", {x, y}, 0);
    ld_valid = 1'b0;
    tick();
  endtask

  // stand-in engine: DONE after 'delay' WAIT cycles, then check the report
  task automatic run_done(input int ax, input int ay, input int bx, input int by,
                          input int delay, input int exp_score, input string name);
    int n;
    c1x = 4'(ax); c1y = 4'(ay); c2x = 4'(bx); c2y = 4'(by);
    repeat (delay) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    c1x = 4'($urandom_range(0, 15)); c1y = 4'($urandom_range(0, 15));
    c2x = 4'($urandom_range(0, 15)); c2y = 4'($urandom_range(0, 15));
    n = 1;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 41);
    chk({name, "_score"}, res_score, exp_score);
    chk({name, "_err"}, res_err, 0);
    chk({name, "_centres"}, {res_c1x, res_c1y, res_c2x, res_c2y},
        {4'(ax), 4'(ay), 4'(bx), 4'(by)});
    tick();
    chk({name, "_valid_one_cycle"}, res_valid, 0);
    chk({name, "_back_to_load"}, ld_ready, 1);
    chk({name, "_score_held"}, res_score, exp_score);
  endtask

  initial begin
    int n, exp_s;

    vecs[0]  = '{4, 0, 0, 0, 0, 0, 40};
    vecs[1]  = '{0, 4, 0, 0, 0, 0, 40};
    vecs[2]  = '{2, 3, 0, 0, 0, 0, 40};
    vecs[3]  = '{3, 3, 0, 0, 0, 0, 0};
    vecs[4]  = '{4, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{15, 15, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 4, 0, 15, 15, 40};
    vecs[7]  = '{8, 8, 0, 0, 8, 8, 40};
    vecs[8]  = '{5, 5, 3, 3, 6, 6, 40};
    vecs[9]  = '{10, 12, 7, 9, 15, 0, 0};
    vecs[10] = '{15, 0, 11, 0, 0, 15, 40};
    vecs[11] = '{0, 15, 0, 11, 0, 11, 40};

    // reset with random inputs
    rst = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_x = 4'($urandom_range(0, 15)); ld_y = 4'($urandom_range(0, 15));
      c1x = 4'($urandom_range(0, 15)); c1y = 4'($urandom_range(0, 15));
      c2x = 4'($urandom_range(0, 15)); c2y = 4'($urandom_range(0, 15));
      done = 1'($urandom_range(0, 1));
      tick();
    end
    chk_all_zero("reset");
    ld_valid = 1'b0;
    done = 1'b0;
    rst = 1'b1;
    chk("ld_ready_before_edge", ld_ready, 0);
    tick();
    chk("ld_ready_after_release", ld_ready, 1);
    chk("l_rst_after_release", l_rst, 0);

    // alignment pattern with load gaps, stray DONE and junk loads while streaming
    for (int k = 0; k < 40; k++) begin
      pt_x[k] = 4'(k % 16);
      pt_y[k] = 4'(k / 3);
    end
    load_pattern(1'b1);
    stream_check(1'b1);
    exp_s = model_score(3, 3, 12, 12);
    run_done(3, 3, 12, 12, 5, exp_s, "align");

    // fixed response: 20 near C1, 10 on C2 boundary, 10 far
    for (int k = 0; k < 40; k++) begin
      if (k < 20) begin
        pt_x[k] = 4'(1 + k % 5); pt_y[k] = 4'(2 + k % 3);
      end else if (k < 30) begin
        pt_x[k] = 4'd8; pt_y[k] = 4'd12;
      end else begin
        pt_x[k] = 4'd0; pt_y[k] = 4'd15;
      end
    end
    load_pattern(1'b0);
    stream_check(1'b0);
    run_done(3, 3, 12, 12, 0, 30, "fixed30");

    // mixed boundary set around the origin: residues 0..2 hit, 7 each
    for (int k = 0; k < 40; k++) begin
      case (k % 6)
        0: begin pt_x[k] = 4'd4;  pt_y[k] = 4'd0;  end
        1: begin pt_x[k] = 4'd0;  pt_y[k] = 4'd4;  end
        2: begin pt_x[k] = 4'd2;  pt_y[k] = 4'd3;  end
        3: begin pt_x[k] = 4'd3;  pt_y[k] = 4'd3;  end
        4: begin pt_x[k] = 4'd4;  pt_y[k] = 4'd1;  end
        default: begin pt_x[k] = 4'd15; pt_y[k] = 4'd15; end
      endcase
    end
    load_pattern(1'b0);
    stream_check(1'b0);
    run_done(0, 0, 0, 0, 2, 21, "mixed_boundary");

    // timeout: engine stays silent
    load_pattern(1'b0);
    stream_check(1'b0);
    c1x = 4'd9; c1y = 4'd9; c2x = 4'd9; c2y = 4'd9;
    n = 0;
    while (!res_valid && n < 5000) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 4096);
    chk("timeout_err", res_err, 1);
    chk("timeout_score", res_score, 0);
    chk("timeout_centres", {res_c1x, res_c1y, res_c2x, res_c2y}, 0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("late_done_no_valid", res_valid, 0);
    chk("late_done_err_held", res_err, 1);
    chk("late_done_in_load", ld_ready, 1);

    // table-driven distance vectors: 40 copies of one point per run
    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < 40; k++) begin
        pt_x[k] = 4'(vecs[v].px);
        pt_y[k] = 4'(vecs[v].py);
      end
      load_pattern(1'b0);
      stream_check(1'b0);
      run_done(vecs[v].c1x, vecs[v].c1y, vecs[v].c2x, vecs[v].c2y, v % 3,
               vecs[v].exp_score, $sformatf("vec%0d", v));
    end

    // mid-run reset during SEND at point 20
    for (int k = 0; k < 40; k++) begin
      pt_x[k] = 4'((k * 5) % 16);
      pt_y[k] = 4'((k * 3 + 1) % 16);
    end
    load_pattern(1'b0);
    repeat (22) tick();
    chk("midrun_pt20_x", x, pt_x[20]);
    rst = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    tick();
    rst = 1'b1;
    tick();
    chk("midrun_release_ready", ld_ready, 1);

    // partial load then reset again: the partial buffer must be dropped
    ld_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ld_x = 4'($urandom_range(0, 15));
      ld_y = 4'($urandom_range(0, 15));
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    for (int k = 0; k < 40; k++) begin
      pt_x[k] = 4'(15 - (k % 16));
      pt_y[k] = 4'((k * 7) % 16);
    end
    load_pattern(1'b0);
    stream_check(1'b0);
    exp_s = model_score(10, 4, 2, 12);
    run_done(10, 4, 2, 12, 1, exp_s, "reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
